// File: rtl/am2901_useq.sv
// Reduced Am2910-style microprogram sequencer: computes the next microaddress
// from opcode, condition and branch field; holds uPC, a LIFO stack and a loop counter.
module am2901_useq #(
    parameter int AW      = 8,
    parameter int STACK_D = 5
) (
    input  logic          cp,
    input  logic          rst,
    input  logic [2:0]    i,
    input  logic          cc,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] y,
    output logic          full,
    output logic          empty,
    output logic          r_zero
);

    localparam int SPW = $clog2(STACK_D + 1);

    typedef enum logic [2:0] {
        OP_JZ   = 3'd0,
        OP_CJP  = 3'd1,
        OP_CJS  = 3'd2,
        OP_CRTN = 3'd3,
        OP_CONT = 3'd4,
        OP_LDCT = 3'd5,
        OP_PUSH = 3'd6,
        OP_RPCT = 3'd7
    } op_e;

    typedef struct packed {
        logic clr;
        logic push;
        logic pop;
        logic ld_r;
        logic dec_r;
    } ctl_t;

    logic [AW-1:0]  upc;
    logic [AW-1:0]  r;
    logic [AW-1:0]  stk [STACK_D];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] top_idx;
    logic [AW-1:0]  y_nxt;
    ctl_t           ctl;

    assign full    = (sp == SPW'(STACK_D));
    assign empty   = (sp == '0);
    assign r_zero  = (r == '0);
    // Guarded index keeps the top-of-stack read in range when the stack is empty.
    assign top_idx = empty ? '0 : SPW'(sp - SPW'(1));

    always_comb begin
        y_nxt = upc;
        ctl   = '0;
        case (op_e'(i))
            OP_JZ: begin
                y_nxt   = '0;
                ctl.clr = 1'b1;
            end
            OP_CJP: if (cc) y_nxt = d;
            OP_CJS: if (cc) begin
                y_nxt    = d;
                ctl.push = 1'b1;
            end
            OP_CRTN: if (cc && !empty) begin
                y_nxt   = stk[top_idx];
                ctl.pop = 1'b1;
            end
            OP_CONT: y_nxt = upc;
            OP_LDCT: ctl.ld_r = 1'b1;
            OP_PUSH: begin
                ctl.push = 1'b1;
                ctl.ld_r = cc;
            end
            OP_RPCT: if (!r_zero) begin
                y_nxt     = d;
                ctl.dec_r = 1'b1;
            end
            default: y_nxt = upc;
        endcase
    end

    // Reset must show up on y immediately, not only after the next edge.
    assign y = rst ? '0 : y_nxt;

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            upc <= '0;
            r   <= '0;
            sp  <= '0;
            for (int k = 0; k < STACK_D; k++) stk[k] <= '0;
        end else begin
            upc <= y_nxt + AW'(1);
            if (ctl.clr) begin
                sp <= '0;
            end else if (ctl.push) begin
                // A push into a full stack silently replaces the top entry.
                if (!full) begin
                    stk[sp] <= upc;
                    sp      <= sp + SPW'(1);
                end else begin
                    stk[STACK_D-1] <= upc;
                end
            end else if (ctl.pop) begin
                sp <= sp - SPW'(1);
            end
            if (ctl.ld_r)       r <= d;
            else if (ctl.dec_r) r <= r - AW'(1);
        end
    end

endmodule

// File: tb/tb_am2901_useq.sv
// Directed bench for am2901_useq: each task drives one scenario and checks
// y / flags against hand-computed values.
module tb_am2901_useq;

    localparam int AW = 8;

    logic          cp = 1'b0;
    logic          rst;
    logic [2:0]    i;
    logic          cc;
    logic [AW-1:0] d;
    logic [AW-1:0] y;
    logic          full, empty, r_zero;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    am2901_useq #(.AW(AW), .STACK_D(5)) dut (
        .cp(cp), .rst(rst), .i(i), .cc(cc), .d(d),
        .y(y), .full(full), .empty(empty), .r_zero(r_zero)
    );

    always #5 cp = ~cp;

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic c, input logic [AW-1:0] dv);
        i  = op;
        cc = c;
        d  = dv;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'd4, 1'b0, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(3'd4, 1'b1, 8'hAA);
        tick();
        tick();
        tot_cnt++;
        if (y !== 8'h00 || empty !== 1'b1 || full !== 1'b0 || r_zero !== 1'b1)
            $display("FAIL reset_state: y=%h empty=%b full=%b r_zero=%b want y=00 empty=1 full=0 r_zero=1",
                     y, empty, full, r_zero);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            drive(3'd4, 1'b0, 8'h00);
            tot_cnt++;
            if (y !== AW'(k)) $display("FAIL cont_seq[%0d]: y=%h want %h", k, y, AW'(k));
            else pass_cnt++;
            tick();
        end
    endtask

    // Entered with upc=5.
    task automatic test_cjp();
        drive(3'd1, 1'b0, 8'h40);
        tot_cnt++;
        if (y !== 8'h05) $display("FAIL cjp_nottaken: y=%h want 05", y);
        else pass_cnt++;
        tick();
        drive(3'd1, 1'b1, 8'h40);
        tot_cnt++;
        if (y !== 8'h40) $display("FAIL cjp_taken: y=%h want 40", y);
        else pass_cnt++;
        tick();
        drive(3'd4, 1'b0, 8'h00);
        tot_cnt++;
        if (y !== 8'h41) $display("FAIL cjp_upc: y=%h want 41", y);
        else pass_cnt++;
    endtask

    task automatic test_subroutine();
        drive(3'd1, 1'b1, 8'h0F);
        tick();
        drive(3'd2, 1'b1, 8'h80);
        tot_cnt++;
        if (y !== 8'h80) $display("FAIL cjs_y: y=%h want 80", y);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (empty !== 1'b0 || full !== 1'b0) $display("FAIL cjs_sp1: empty=%b full=%b want 0 0", empty, full);
        else pass_cnt++;
        drive(3'd3, 1'b0, 8'h00);
        tot_cnt++;
        if (y !== 8'h81) $display("FAIL crtn_cc0: y=%h want 81", y);
        else pass_cnt++;
        drive(3'd3, 1'b1, 8'h00);
        tot_cnt++;
        if (y !== 8'h10) $display("FAIL crtn_pop: y=%h want 10", y);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (empty !== 1'b1) $display("FAIL crtn_empty: empty=%b want 1", empty);
        else pass_cnt++;
        drive(3'd3, 1'b1, 8'h00);
        tot_cnt++;
        if (y !== 8'h11) $display("FAIL crtn_underflow: y=%h want 11", y);
        else pass_cnt++;
        tick();
        drive(3'd2, 1'b0, 8'h80);
        tot_cnt++;
        if (y !== 8'h12) $display("FAIL cjs_cc0: y=%h want 12", y);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (empty !== 1'b1) $display("FAIL cjs_cc0_nopush: empty=%b want 1", empty);
        else pass_cnt++;
    endtask

    // Entered with upc=0x13, r=0.
    task automatic test_loop();
        drive(3'd5, 1'b1, 8'h03);
        tot_cnt++;
        if (y !== 8'h13) $display("FAIL ldct_y: y=%h want 13", y);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (r_zero !== 1'b0) $display("FAIL ldct_r: r_zero=%b want 0", r_zero);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            drive(3'd7, 1'b0, 8'h20);
            tot_cnt++;
            if (y !== 8'h20 || r_zero !== 1'b0)
                $display("FAIL rpct_iter[%0d]: y=%h r_zero=%b want 20 0", k, y, r_zero);
            else pass_cnt++;
            tick();
        end
        drive(3'd7, 1'b0, 8'h20);
        tot_cnt++;
        if (y !== 8'h21 || r_zero !== 1'b1) $display("FAIL rpct_exit: y=%h r_zero=%b want 21 1", y, r_zero);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (r_zero !== 1'b1) $display("FAIL rpct_floor: r_zero=%b want 1", r_zero);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_ret [5];
        exp_ret = '{8'h06, 8'h04, 8'h03, 8'h02, 8'h01};
        do_reset();
        drive(3'd4, 1'b0, 8'h00);
        tick();
        for (int k = 1; k <= 6; k++) begin
            drive(3'd6, 1'b0, 8'hEE);
            tot_cnt++;
            if (y !== AW'(k)) $display("FAIL push_y[%0d]: y=%h want %h", k, y, AW'(k));
            else pass_cnt++;
            tick();
            if (k >= 4) begin
                tot_cnt++;
                if (full !== (k >= 5)) $display("FAIL push_full[%0d]: full=%b want %b", k, full, (k >= 5));
                else pass_cnt++;
            end
        end
        tot_cnt++;
        if (r_zero !== 1'b1) $display("FAIL push_cc0_noload: r_zero=%b want 1", r_zero);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            drive(3'd3, 1'b1, 8'h00);
            tot_cnt++;
            if (y !== exp_ret[k]) $display("FAIL ret_y[%0d]: y=%h want %h", k, y, exp_ret[k]);
            else pass_cnt++;
            tick();
        end
        tot_cnt++;
        if (empty !== 1'b1 || full !== 1'b0) $display("FAIL ret_empty: empty=%b full=%b want 1 0", empty, full);
        else pass_cnt++;
    endtask

    task automatic test_jz();
        drive(3'd6, 1'b0, 8'h00);
        tick();
        drive(3'd0, 1'b1, 8'h77);
        tot_cnt++;
        if (y !== 8'h00) $display("FAIL jz_y: y=%h want 00", y);
        else pass_cnt++;
        tick();
        drive(3'd4, 1'b0, 8'h00);
        tot_cnt++;
        if (y !== 8'h01 || empty !== 1'b1) $display("FAIL jz_clear: y=%h empty=%b want 01 1", y, empty);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(3'd6, 1'b0, 8'h00);
        tick();
        drive(3'd6, 1'b1, 8'h02);
        tick();
        drive(3'd7, 1'b0, 8'h50);
        tot_cnt++;
        if (y !== 8'h50 || r_zero !== 1'b0 || empty !== 1'b0)
            $display("FAIL pre_reset: y=%h r_zero=%b empty=%b want 50 0 0", y, r_zero, empty);
        else pass_cnt++;
        #1;
        rst = 1'b1;
        #1;
        tot_cnt++;
        if (y !== 8'h00 || empty !== 1'b1 || r_zero !== 1'b1 || full !== 1'b0)
            $display("FAIL async_reset: y=%h empty=%b r_zero=%b full=%b want 00 1 1 0", y, empty, r_zero, full);
        else pass_cnt++;
        #1;
        rst = 1'b0;
        #1;
        drive(3'd7, 1'b0, 8'h50);
        tot_cnt++;
        if (y !== 8'h00) $display("FAIL post_reset_r: y=%h want 00", y);
        else pass_cnt++;
        drive(3'd3, 1'b1, 8'h00);
        tot_cnt++;
        if (y !== 8'h00) $display("FAIL post_reset_sp: y=%h want 00", y);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        drive(3'd1, 1'b1, 8'hFE);
        tick();
        drive(3'd4, 1'b1, 8'h33);
        tot_cnt++;
        if (y !== 8'hFF) $display("FAIL wrap_pre: y=%h want ff", y);
        else pass_cnt++;
        tick();
        drive(3'd4, 1'b0, 8'h00);
        tot_cnt++;
        if (y !== 8'h00) $display("FAIL wrap_upc: y=%h want 00", y);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        i   = 3'd4;
        cc  = 1'b0;
        d   = '0;
        test_reset();
        test_cjp();
        test_subroutine();
        test_loop();
        test_overflow();
        test_jz();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
